// File: rtl/pe_array_pkg.sv
// Shared state encoding, default sizing and helpers for the PE array controller.
package pe_array_pkg;

    localparam int unsigned DefArraySize            = 2;
    localparam int unsigned DefComputeDataWidth     = 4;
    localparam int unsigned DefAccumulatorDataWidth = 16;
    localparam int unsigned DefCountWidth           = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain,
        StDone
    } state_e;

    // Bits needed for a counter that must reach max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth register delay line; used per lane for input skew and result deskew.
module skew_line #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Depth-1:0][Width-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int unsigned k = 1; k < Depth; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign q_o = pipe_q[Depth-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Job controller for a weight-stationary PE array: loads weight rows, streams skewed
// activation vectors, and reassembles deskewed column results.
module pe_array_ctrl
    import pe_array_pkg::*;
#(
    parameter int unsigned ARRAY_SIZE             = DefArraySize,
    parameter int unsigned COMPUTE_DATA_WIDTH     = DefComputeDataWidth,
    parameter int unsigned ACCUMULATOR_DATA_WIDTH = DefAccumulatorDataWidth,
    parameter int unsigned COUNT_WIDTH            = DefCountWidth
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic                                                 start_i,
    input  logic [COUNT_WIDTH-1:0]                               num_vectors_i,
    input  logic                                                 in_valid_i,
    output logic                                                 in_ready_o,
    input  logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0]        in_data_i,
    output logic                                                 load_en_o,
    output logic                                                 compute_o,
    output logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0]        ins_o,
    input  logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]    results_i,
    output logic                                                 out_valid_o,
    output logic [ARRAY_SIZE-1:0][ACCUMULATOR_DATA_WIDTH-1:0]    out_data_o,
    output logic                                                 busy_o,
    output logic                                                 done_o
);

    // One counter serves both the load-beat count and the drain length.
    localparam int unsigned      PhaseW    = cnt_width(2 * ARRAY_SIZE - 1);
    localparam logic [PhaseW-1:0] LoadLast  = PhaseW'(ARRAY_SIZE - 1);
    localparam logic [PhaseW-1:0] DrainLast = PhaseW'(2 * ARRAY_SIZE - 1);

    state_e                 state_q;
    logic [PhaseW-1:0]      phase_q;
    logic [COUNT_WIDTH-1:0] vec_cnt_q;
    logic [COUNT_WIDTH-1:0] num_q;
    logic                   in_ready_q;
    logic                   compute_q;
    logic                   busy_q;
    logic                   done_q;

    logic accept;
    logic load_accept;
    logic comp_accept;
    logic last_vec;

    assign accept      = in_valid_i & in_ready_q;
    assign load_accept = accept & (state_q == StLoad);
    assign comp_accept = accept & (state_q == StCompute);
    assign last_vec    = (vec_cnt_q == (num_q - COUNT_WIDTH'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            vec_cnt_q  <= '0;
            num_q      <= '0;
            in_ready_q <= 1'b0;
            compute_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q    <= StLoad;
                        num_q      <= num_vectors_i;
                        phase_q    <= '0;
                        vec_cnt_q  <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (phase_q == LoadLast) begin
                            phase_q <= '0;
                            if (num_q == '0) begin
                                state_q    <= StDone;
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                            end else begin
                                state_q   <= StCompute;
                                compute_q <= 1'b1;
                            end
                        end else begin
                            phase_q <= phase_q + PhaseW'(1);
                        end
                    end
                end
                StCompute: begin
                    if (accept) begin
                        if (last_vec) begin
                            state_q    <= StDrain;
                            in_ready_q <= 1'b0;
                            phase_q    <= '0;
                        end else begin
                            vec_cnt_q <= vec_cnt_q + COUNT_WIDTH'(1);
                        end
                    end
                end
                StDrain: begin
                    // Drain long enough for the last vector to clear skew and deskew.
                    if (phase_q == DrainLast) begin
                        state_q   <= StDone;
                        compute_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        phase_q <= phase_q + PhaseW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    compute_q  <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_q;
    assign load_en_o  = load_accept;
    assign compute_o  = compute_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] skew_in;
    logic [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] skew_out;

    // Lane i is delayed i cycles; weight rows bypass the skew during LOAD.
    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        assign skew_in[i] = comp_accept ? in_data_i[i] : '0;
        if (i == 0) begin : g_direct
            assign skew_out[i] = skew_in[i];
        end else begin : g_delay
            skew_line #(
                .Width (COMPUTE_DATA_WIDTH),
                .Depth (i)
            ) u_skew (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .d_i    (skew_in[i]),
                .q_o    (skew_out[i])
            );
        end
        assign ins_o[i] = load_accept ? in_data_i[i] : skew_out[i];
    end

    // Column j appears ARRAY_SIZE+j after acceptance; delay it to align at 2*ARRAY_SIZE.
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_col
        skew_line #(
            .Width (ACCUMULATOR_DATA_WIDTH),
            .Depth (ARRAY_SIZE - j)
        ) u_deskew (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (results_i[j]),
            .q_o    (out_data_o[j])
        );
    end

    skew_line #(
        .Width (1),
        .Depth (2 * ARRAY_SIZE)
    ) u_valid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (comp_accept),
        .q_o    (out_valid_o)
    );

    a_no_out_on_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
        done_o |-> !out_valid_o);
    a_strobes_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(load_en_o && compute_o));

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Self-checking bench for pe_array_ctrl with a timestamp-based job model and a PE array model.
module tb_pe_array_ctrl;

    localparam int N  = 2;
    localparam int CW = 4;
    localparam int AW = 16;
    localparam int NW = 8;

    typedef logic [N-1:0][CW-1:0] lane_t;
    typedef logic [N-1:0][AW-1:0] res_t;

    typedef struct {
        int          num;
        logic [7:0]  r0;
        logic [7:0]  r1;
        logic [7:0]  v    [3];
        logic [31:0] want [3];
        int          gap;
        bit          start_mid;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] num_vectors = '0;
    logic          in_valid = 1'b0;
    lane_t         in_data = '0;
    res_t          results = '0;
    logic          in_ready, load_en, compute, out_valid, busy, done;
    lane_t         ins;
    res_t          out_data;

    pe_array_ctrl #(
        .ARRAY_SIZE             (N),
        .COMPUTE_DATA_WIDTH     (CW),
        .ACCUMULATOR_DATA_WIDTH (AW),
        .COUNT_WIDTH            (NW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start),
        .num_vectors_i (num_vectors),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_data_i     (in_data),
        .load_en_o     (load_en),
        .compute_o     (compute),
        .ins_o         (ins),
        .results_i     (results),
        .out_valid_o   (out_valid),
        .out_data_o    (out_data),
        .busy_o        (busy),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 64;

    // Job model: a job is described by its beat count and the cycle done is due.
    bit          m_on = 1'b0;
    bit          m_end = 1'b0;
    int          m_num = 0;
    int          m_beats = 0;
    int          m_t_done = 0;
    logic [CW-1:0] w [N][N];
    bit          ring_v [64];
    lane_t       ring_d [64];

    logic [N*AW-1:0] obs_q [$];
    int              obs_cyc [$];
    int              done_cnt = 0;
    int              done_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] dot(input lane_t v, input int j);
        logic [AW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s += AW'(v[i]) * AW'(w[i][j]);
        return s;
    endfunction

    task automatic model_reset();
        m_on  = 1'b0;
        m_end = 1'b0;
        for (int k = 0; k < 64; k++) ring_v[k] = 1'b0;
    endtask

    // One clock cycle: predict, drive the array model, compare at negedge, advance the model.
    task automatic tick();
        bit    acc, ld, cp, exp_ready, exp_done, exp_comp, exp_ov;
        int    b;
        lane_t exp_ins;
        res_t  exp_od;
        exp_ready = m_on && (m_beats < N + m_num);
        acc = (in_valid === 1'b1) && exp_ready;
        ld  = acc && (m_beats < N);
        cp  = acc && !ld;
        ring_v[cyc % 64] = cp;
        ring_d[cyc % 64] = in_data;
        for (int j = 0; j < N; j++) begin
            b = (cyc - N - j) % 64;
            results[j] = ring_v[b] ? dot(ring_d[b], j) : AW'($urandom);
        end
        for (int i = 0; i < N; i++) begin
            b = (cyc - i) % 64;
            exp_ins[i] = ld ? in_data[i] : (ring_v[b] ? ring_d[b][i] : '0);
        end
        b = (cyc - 2 * N) % 64;
        exp_ov = ring_v[b];
        for (int j = 0; j < N; j++) exp_od[j] = dot(ring_d[b], j);
        exp_done = m_on && m_end && (cyc == m_t_done);
        exp_comp = m_on && (m_num > 0) && (m_beats >= N) && !exp_done;

        @(negedge clk);
        check("in_ready", in_ready, exp_ready);
        check("load_en", load_en, ld);
        check("compute", compute, exp_comp);
        check("busy", busy, m_on);
        check("done", done, exp_done);
        check("out_valid", out_valid, exp_ov);
        check("ins", ins, exp_ins);
        if (exp_ov) check("out_data", out_data, exp_od);
        if (out_valid === 1'b1) begin
            obs_q.push_back(out_data);
            obs_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end

        if (m_on) begin
            if (exp_done) begin
                m_on = 1'b0;
            end else if (acc) begin
                if (ld) for (int j = 0; j < N; j++) w[m_beats][j] = in_data[j];
                m_beats++;
                if (m_beats == N + m_num) begin
                    m_end    = 1'b1;
                    m_t_done = (m_num == 0) ? cyc + 1 : cyc + 2 * N + 1;
                end
            end
        end else if (start === 1'b1 && rst_ni === 1'b1) begin
            m_on    = 1'b1;
            m_end   = 1'b0;
            m_beats = 0;
            m_num   = int'(num_vectors);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_job(input int num, input lane_t r0, input lane_t r1,
                             input lane_t vecs[$], input int gap, input bit start_mid);
        int guard;
        obs_q.delete();
        obs_cyc.delete();
        done_cnt = 0;
        start = 1'b1; num_vectors = NW'(num); in_valid = 1'b0; tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = r0; tick();
        in_data = r1; tick();
        foreach (vecs[k]) begin
            if (k > 0) begin
                repeat (gap) begin
                    in_valid = 1'b0; in_data = lane_t'($urandom); tick();
                end
            end
            in_valid = 1'b1; in_data = vecs[k];
            start = start_mid && (k == 1);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        guard = 0;
        while (m_on && guard < 1000) begin
            tick();
            guard++;
        end
        tick();
        tick();
    endtask

    initial begin
        job_t  tbl [5];
        lane_t vq [$];
        int    guard;

        tbl[0] = '{1, 8'h21, 8'h43, '{8'h11, 8'h00, 8'h00},
                   '{32'h0006_0004, 32'h0, 32'h0}, 0, 1'b0};
        tbl[1] = '{3, 8'h21, 8'h43, '{8'h01, 8'h10, 8'h22},
                   '{32'h0002_0001, 32'h0004_0003, 32'h000C_0008}, 0, 1'b0};
        tbl[2] = '{2, 8'h21, 8'h43, '{8'h01, 8'h10, 8'h00},
                   '{32'h0002_0001, 32'h0004_0003, 32'h0}, 1, 1'b0};
        tbl[3] = '{0, 8'h21, 8'h43, '{8'h00, 8'h00, 8'h00},
                   '{32'h0, 32'h0, 32'h0}, 0, 1'b0};
        tbl[4] = '{2, 8'h21, 8'h43, '{8'h22, 8'h11, 8'h00},
                   '{32'h000C_0008, 32'h0006_0004, 32'h0}, 0, 1'b1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_load_en", load_en, 0);
        check("rst_compute", compute, 0);
        check("rst_ins", ins, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();

        for (int t = 0; t < 5; t++) begin
            vq.delete();
            for (int k = 0; k < tbl[t].num; k++) vq.push_back(tbl[t].v[k]);
            drive_job(tbl[t].num, tbl[t].r0, tbl[t].r1, vq, tbl[t].gap, tbl[t].start_mid);
            check($sformatf("job%0d_out_count", t), obs_q.size(), tbl[t].num);
            check($sformatf("job%0d_done_count", t), done_cnt, 1);
            for (int k = 0; k < tbl[t].num; k++) begin
                if (k < obs_q.size())
                    check($sformatf("job%0d_out%0d", t, k), obs_q[k], tbl[t].want[k]);
                if (k > 0 && k < obs_q.size())
                    check($sformatf("job%0d_spacing%0d", t, k), obs_cyc[k] - obs_cyc[k-1],
                          tbl[t].gap + 1);
            end
            if (tbl[t].num > 0 && obs_q.size() > 0)
                check($sformatf("job%0d_done_after_last", t), done_cyc - obs_cyc[$], 1);
        end

        // Largest vector count must complete without counter wrap.
        vq.delete();
        for (int k = 0; k < 255; k++) vq.push_back(lane_t'($urandom));
        drive_job(255, lane_t'($urandom), lane_t'($urandom), vq, 0, 1'b0);
        check("max_job_out_count", obs_q.size(), 255);
        check("max_job_done_count", done_cnt, 1);

        // Reset in the middle of COMPUTE.
        start = 1'b1; num_vectors = 8'd3; in_valid = 1'b0; tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h21; tick();
        in_data = 8'h43; tick();
        in_data = 8'h11; tick();
        in_data = 8'h22;
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_load_en", load_en, 0);
        check("midrst_compute", compute, 0);
        check("midrst_ins", ins, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        model_reset();
        tick();
        tick();
        rst_ni = 1'b1;
        obs_q.delete();
        done_cnt = 0;
        repeat (20) begin
            in_valid = 1'($urandom);
            in_data  = lane_t'($urandom);
            tick();
        end
        check("post_rst_out_valid_count", obs_q.size(), 0);
        check("post_rst_done_count", done_cnt, 0);

        // Random traffic: starts at any time, bubbles, short jobs including empty ones.
        repeat (1500) begin
            start       = ($urandom % 6) == 0;
            num_vectors = NW'($urandom_range(0, 5));
            in_valid    = ($urandom % 4) != 0;
            in_data     = lane_t'($urandom);
            tick();
        end
        start = 1'b0;
        in_valid = 1'b0;
        guard = 0;
        while (m_on && guard < 200) begin
            tick();
            guard++;
        end
        check("random_settled_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
